// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   state_e            : FSM state encoding used by fsm_seq_tx
//   IDLE_LEVEL_DEFAULT : default x_out level when no pattern bit is driven
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

endpackage

// File: rtl/fsm_seq_shreg.sv
// Loadable MSB-first shift register for one pattern frame.
// Ports:
//   clk_i      : clock, updates on posedge
//   rst_i      : synchronous active-high clear
//   load_i     : load din_i (has priority over shift_i)
//   shift_i    : shift left by one, zero-fill at the LSB
//   din_i      : parallel frame to load
//   msb_next_o : MSB the register will hold after the coming edge, so the
//                parent can register it as its serial output in the same cycle
module fsm_seq_shreg #(
  parameter int PATTERN_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [PATTERN_W-1:0] din_i,
  output logic                 msb_next_o
);

  logic [PATTERN_W-1:0] sr_q;
  logic [PATTERN_W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = din_i;
    end else if (shift_i) begin
      sr_d = {sr_q[PATTERN_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_next_o = sr_d[PATTERN_W-1];

endmodule

// File: rtl/fsm_seq_tx.sv
// Serial pattern transmitter: sends a parallel pattern MSB-first, repeated
// reps times with gap idle cycles between frames, then pulses done.
// Ports:
//   CLK        : clock, all state on posedge
//   Reset      : synchronous active-high reset, aborts any job silently
//   start      : request strobe, only honoured in IDLE
//   pattern_in : frame to send (MSB first)
//   reps_in    : number of frames (0 behaves as 1)
//   gap_in     : idle cycles between consecutive frames
//   x_out      : serial data line
//   x_valid    : high while x_out carries a pattern bit
//   busy       : high while a job is in SEND/GAP
//   done       : one-cycle pulse after the last bit of the last frame
module fsm_seq_tx
  import fsm_seq_pkg::*;
#(
  parameter int   PATTERN_W  = 4,
  parameter int   REP_W      = 3,
  parameter int   GAP_W      = 3,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [PATTERN_W-1:0] pattern_in,
  input  logic [REP_W-1:0]     reps_in,
  input  logic [GAP_W-1:0]     gap_in,
  output logic                 x_out,
  output logic                 x_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int              BIT_W    = $clog2(PATTERN_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PATTERN_W - 1);

  state_e               state_q,   state_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0]     rep_cnt_q, rep_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0]     gap_rld_q, gap_rld_d;
  logic [PATTERN_W-1:0] frame_q,   frame_d;

  logic x_out_q,   x_out_d;
  logic x_valid_q, x_valid_d;
  logic busy_q,    busy_d;
  logic done_q,    done_d;

  logic                 sr_load;
  logic                 sr_shift;
  logic [PATTERN_W-1:0] sr_din;
  logic                 sr_msb_next;

  // A fresh job loads straight from the input; repeats reload the latched
  // copy because the inputs need not be held after acceptance.
  assign sr_din = (state_q == ST_IDLE) ? pattern_in : frame_q;

  fsm_seq_shreg #(
    .PATTERN_W (PATTERN_W)
  ) u_shreg (
    .clk_i      (CLK),
    .rst_i      (Reset),
    .load_i     (sr_load),
    .shift_i    (sr_shift),
    .din_i      (sr_din),
    .msb_next_o (sr_msb_next)
  );

  // State and output registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      gap_rld_q <= '0;
      frame_q   <= '0;
      x_out_q   <= IDLE_LEVEL;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      gap_rld_q <= gap_rld_d;
      frame_q   <= frame_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    gap_rld_d = gap_rld_q;
    frame_d   = frame_q;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SEND;
          frame_d   = pattern_in;
          rep_cnt_d = (reps_in == '0) ? REP_W'(1) : reps_in;
          gap_rld_d = gap_in;
          bit_cnt_d = '0;
          sr_load   = 1'b1;
        end
      end

      ST_SEND: begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          if (rep_cnt_q > REP_W'(1)) begin
            if (gap_rld_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_rld_q;
            end else begin
              // Zero gap: reload now so the next frame follows with no bubble.
              sr_load   = 1'b1;
              rep_cnt_d = rep_cnt_q - REP_W'(1);
            end
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          sr_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end

      ST_GAP: begin
        // gap_cnt_q counts remaining idle cycles including the current one.
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d   = ST_SEND;
          gap_cnt_d = '0;
          sr_load   = 1'b1;
          rep_cnt_d = rep_cnt_q - REP_W'(1);
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so they can be registered
  // and still line up with the state they describe.
  always_comb begin
    x_out_d   = IDLE_LEVEL;
    x_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_d)
      ST_SEND: begin
        x_out_d   = sr_msb_next;
        x_valid_d = 1'b1;
        busy_d    = 1'b1;
      end
      ST_GAP: begin
        busy_d = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        x_out_d = IDLE_LEVEL;
      end
    endcase
  end

  assign x_out   = x_out_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_fsm_seq_tx.sv
// Directed bench for fsm_seq_tx (PATTERN_W=4) with a small 1011 detector
// hanging off the serial line for the loopback sequence.
module tb_fsm_seq_tx;

  logic       CLK;
  logic       Reset;
  logic       start;
  logic [3:0] pattern_in;
  logic [2:0] reps_in;
  logic [2:0] gap_in;
  logic       x_out;
  logic       x_valid;
  logic       busy;
  logic       done;

  int n_total = 0;
  int n_pass  = 0;

  fsm_seq_tx #(
    .PATTERN_W  (4),
    .REP_W      (3),
    .GAP_W      (3),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .start      (start),
    .pattern_in (pattern_in),
    .reps_in    (reps_in),
    .gap_in     (gap_in),
    .x_out      (x_out),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Sequence detector for 1011 on valid bits, registered output.
  logic [3:0] det_hist;
  logic       det_y;
  always_ff @(posedge CLK) begin
    if (Reset) begin
      det_hist <= '0;
      det_y    <= 1'b0;
    end else begin
      det_y <= x_valid && ({det_hist[2:0], x_out} == 4'b1011);
      if (x_valid) det_hist <= {det_hist[2:0], x_out};
    end
  end

  typedef struct {
    logic [3:0]  pat;
    logic [2:0]  reps;
    logic [2:0]  gap;
    int          len;   // cycles from first bit to last bit/gap before done
    logic [15:0] ex;    // expected x_out, cycle 1 in bit 15
    logic [15:0] ev;    // expected x_valid, cycle 1 in bit 15
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drives start for one sampling edge; returns at the middle of cycle 1.
  task automatic start_job(input logic [3:0] pat, input logic [2:0] reps, input logic [2:0] gap);
    @(negedge CLK);
    start      = 1'b1;
    pattern_in = pat;
    reps_in    = reps;
    gap_in     = gap;
    @(negedge CLK);
    start      = 1'b0;
    pattern_in = ~pat;
    reps_in    = 3'd7;
    gap_in     = 3'd5;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int done_seen;

    vecs[0] = '{4'b1011, 3'd1, 3'd0, 4,  16'b1011_0000_0000_0000, 16'b1111_0000_0000_0000};
    vecs[1] = '{4'b1101, 3'd2, 3'd0, 8,  16'b1101_1101_0000_0000, 16'b1111_1111_0000_0000};
    vecs[2] = '{4'b1001, 3'd2, 3'd3, 11, 16'b1001_0001_0010_0000, 16'b1111_0001_1110_0000};
    vecs[3] = '{4'b0110, 3'd0, 3'd0, 4,  16'b0110_0000_0000_0000, 16'b1111_0000_0000_0000};
    vecs[4] = '{4'b1011, 3'd3, 3'd1, 14, 16'b1011_0101_1010_1100, 16'b1111_0111_1011_1100};

    Reset      = 1'b1;
    start      = 1'b0;
    pattern_in = 4'h0;
    reps_in    = 3'd0;
    gap_in     = 3'd0;
    repeat (3) @(negedge CLK);
    check("rst x_out",   x_out,   1'b0);
    check("rst x_valid", x_valid, 1'b0);
    check("rst busy",    busy,    1'b0);
    check("rst done",    done,    1'b0);
    Reset = 1'b0;

    // Reset during the second bit of a 3-frame job.
    start_job(4'b1011, 3'd3, 3'd2);
    check("mid c1 x_out", x_out, 1'b1);
    @(negedge CLK);
    check("mid c2 x_out",   x_out,   1'b0);
    check("mid c2 x_valid", x_valid, 1'b1);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    check("mid after x_out",   x_out,   1'b0);
    check("mid after x_valid", x_valid, 1'b0);
    check("mid after busy",    busy,    1'b0);
    check("mid after done",    done,    1'b0);
    done_seen = 0;
    repeat (25) begin
      @(negedge CLK);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("mid no activity after abort", done_seen, 0);

    // Table-driven jobs.
    for (int i = 0; i < 5; i++) begin
      start_job(vecs[i].pat, vecs[i].reps, vecs[i].gap);
      for (int c = 1; c <= vecs[i].len; c++) begin
        if (c > 1) @(negedge CLK);
        check($sformatf("v%0d c%0d x_out", i, c),   x_out,   vecs[i].ex[16-c]);
        check($sformatf("v%0d c%0d x_valid", i, c), x_valid, vecs[i].ev[16-c]);
        check($sformatf("v%0d c%0d busy", i, c),    busy,    1'b1);
        check($sformatf("v%0d c%0d done", i, c),    done,    1'b0);
      end
      @(negedge CLK);
      check($sformatf("v%0d done pulse", i),   done,    1'b1);
      check($sformatf("v%0d done busy", i),    busy,    1'b0);
      check($sformatf("v%0d done x_valid", i), x_valid, 1'b0);
      check($sformatf("v%0d done x_out", i),   x_out,   1'b0);
      @(negedge CLK);
      check($sformatf("v%0d after done", i), done, 1'b0);
      check($sformatf("v%0d after busy", i), busy, 1'b0);
    end

    // reps 0, start ignored mid-job and during DONE, accepted right after.
    start_job(4'b0110, 3'd0, 3'd0);
    check("ign c1 x_out", x_out, 1'b0);
    @(negedge CLK);
    check("ign c2 x_out", x_out, 1'b1);
    start      = 1'b1;
    pattern_in = 4'b1111;
    reps_in    = 3'd7;
    @(negedge CLK);
    start = 1'b0;
    check("ign c3 x_out", x_out, 1'b1);
    @(negedge CLK);
    check("ign c4 x_out",   x_out,   1'b0);
    check("ign c4 x_valid", x_valid, 1'b1);
    @(negedge CLK);
    check("ign c5 done", done, 1'b1);
    start      = 1'b1;
    pattern_in = 4'b1000;
    reps_in    = 3'd1;
    gap_in     = 3'd0;
    @(negedge CLK);
    check("ign c6 done",    done,    1'b0);
    check("ign c6 busy",    busy,    1'b0);
    check("ign c6 x_valid", x_valid, 1'b0);
    @(negedge CLK);
    start = 1'b0;
    check("re c7 x_valid", x_valid, 1'b1);
    check("re c7 x_out",   x_out,   1'b1);
    check("re c7 busy",    busy,    1'b1);
    for (int c = 8; c <= 10; c++) begin
      @(negedge CLK);
      check($sformatf("re c%0d x_out", c), x_out, 1'b0);
    end
    @(negedge CLK);
    check("re c11 done", done, 1'b1);

    // Loopback into detector: 1011, reps 2, gap 1.
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    start_job(4'b1011, 3'd2, 3'd1);
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge CLK);
      check($sformatf("loop c%0d det_y", c), det_y, (c == 5 || c == 10) ? 1'b1 : 1'b0);
      check($sformatf("loop c%0d done", c),  done,  (c == 10) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
